// File: rtl/entity_line_renderer.sv
// entity_line_renderer: scans the entity list for one screen row and paints every overlapping entity into the line buffer
module entity_line_renderer #(
  parameter int ENT_SIZE   = 48,
  parameter int LINE_WIDTH = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [7:0]  entities_number,
  output logic [7:0]  address_read_ent,
  input  logic [20:0] data_read_ent,
  output logic [8:0]  lb_address,
  output logic [2:0]  lb_data,
  output logic        lb_wren,
  output logic        busy,
  output logic        line_done
);
  localparam logic [8:0] ENT9 = 9'(ENT_SIZE);
  localparam logic [5:0] LAST = 6'(ENT_SIZE - 1);
  localparam logic [9:0] LW10 = 10'(LINE_WIDTH);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  ly_q, ly_d;
  logic [7:0]  num_q, num_d;
  logic [7:0]  idx_q, idx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [8:0]  x_q, x_d;
  logic [2:0]  typ_q, typ_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  col_q, col_d;
  logic [2:0]  dat_q, dat_d;
  logic        wren_q, wren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [8:0]  dy;
  logic        hit, adv, last;

  // Next-state logic; outputs are derived from the next state so they line up with the registered state
  always_comb begin
    state_d = state_q;
    ly_d    = ly_q;
    num_d   = num_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    typ_d   = typ_q;
    dy      = ly_q - data_read_ent[17:9];
    hit     = dy < ENT9;
    last    = ({1'b0, idx_q} + 9'd1) == {1'b0, num_q};
    adv     = (state_q == CHECK && !hit) || (state_q == FILL && cnt_q == LAST);
    case (state_q)
      IDLE: if (line_start) begin
        ly_d    = line_y;
        num_d   = entities_number;
        idx_d   = '0;
        state_d = (entities_number == 8'd0) ? DONE : READ;
      end
      READ:  state_d = WAIT;
      WAIT:  state_d = CHECK;
      CHECK: if (hit) begin
        x_d     = data_read_ent[8:0];
        typ_d   = data_read_ent[20:18];
        cnt_d   = '0;
        state_d = FILL;
      end
      FILL:  cnt_d = cnt_q + 6'd1;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      state_d = last ? DONE : READ;
      idx_d   = last ? idx_q : idx_q + 8'd1;
    end
    col_d  = (state_d == FILL) ? x_d + {3'b000, cnt_d} : '0;
    addr_d = idx_d;
    dat_d  = (state_d == FILL) ? typ_d : '0;
    wren_d = (state_d == FILL) && ({1'b0, col_d} < LW10);
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  // State and registered outputs; reset aborts any render immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ly_q    <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      typ_q   <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      dat_q   <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ly_q    <= ly_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      typ_q   <= typ_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      dat_q   <= dat_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign address_read_ent = addr_q;
  assign lb_address       = col_q;
  assign lb_data          = dat_q;
  assign lb_wren          = wren_q;
  assign busy             = busy_q;
  assign line_done        = done_q;
endmodule

// File: tb/tb_entity_line_renderer.sv
// tb_entity_line_renderer: directed table plus randomized renders checked against a list-walking line model
module tb_entity_line_renderer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = '0;
  logic [7:0]  entities_number = '0;
  logic [7:0]  address_read_ent;
  logic [20:0] data_read_ent;
  logic [8:0]  lb_address;
  logic [2:0]  lb_data;
  logic        lb_wren, busy, line_done;

  int total = 0;
  int bad = 0;
  logic [20:0] mem [256];
  int exp_lb [512];
  int exp_cyc, exp_wr;

  typedef struct {
    logic [20:0] e0;
    logic [20:0] e1;
    int n, ly, cyc, wr, mn, mx;
    bit noise;
  } vec_t;
  vec_t vt [9];

  entity_line_renderer dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_y(line_y),
    .entities_number(entities_number), .address_read_ent(address_read_ent),
    .data_read_ent(data_read_ent), .lb_address(lb_address), .lb_data(lb_data),
    .lb_wren(lb_wren), .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  // synchronous entity RAM: data follows the address one clock later
  always @(posedge clk) data_read_ent <= mem[address_read_ent];

  function automatic logic [20:0] ent(input int t, input int y, input int x);
    return {3'(t), 9'(y), 9'(x)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // painter's model: walk the list in order, overlapping rows paint 48 columns modulo 512
  task automatic model(input int ly, input int n);
    int t, y, x, col;
    exp_cyc = 1;
    exp_wr = 0;
    foreach (exp_lb[c]) exp_lb[c] = -1;
    for (int i = 0; i < n; i++) begin
      t = int'(mem[i][20:18]);
      y = int'(mem[i][17:9]);
      x = int'(mem[i][8:0]);
      if ((ly - y + 512) % 512 < 48) begin
        exp_cyc += 51;
        for (int c = 0; c < 48; c++) begin
          col = (x + c) % 512;
          if (col < 480) begin
            exp_lb[col] = t;
            exp_wr++;
          end
        end
      end else exp_cyc += 3;
    end
  endtask

  task automatic run(input int ly, input int n, input bit noise, output int cyc,
                     output int wr, output int mn, output int mx, output int bad_cols);
    int act_lb [512];
    int busy_err;
    foreach (act_lb[c]) act_lb[c] = -1;
    wr = 0; mn = 999; mx = -1; busy_err = 0; bad_cols = 0;
    @(negedge clk);
    line_start = 1'b1;
    line_y = 9'(ly);
    entities_number = 8'(n);
    @(posedge clk); #1;
    line_start = 1'b0;
    cyc = 1;
    while (!line_done && cyc < 5000) begin
      if (!busy) busy_err++;
      if (lb_wren) begin
        wr++;
        act_lb[lb_address] = int'(lb_data);
        if (int'(lb_address) < mn) mn = int'(lb_address);
        if (int'(lb_address) > mx) mx = int'(lb_address);
      end
      if (noise) begin
        @(negedge clk);
        line_start = 1'($urandom);
        line_y = 9'($urandom);
        entities_number = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    line_start = 1'b0;
    chk("done_seen", int'(line_done), 1);
    chk("busy_during_render", busy_err + (busy ? 0 : 1), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'({line_done, busy}), 0);
    foreach (act_lb[c]) if (act_lb[c] != exp_lb[c]) bad_cols++;
  endtask

  initial begin
    int cyc, wr, mn, mx, bc, cnt, ly, n, y;
    foreach (mem[i]) mem[i] = '0;
    vt[0] = '{21'd0, 21'd0, 0, 100, 1, 0, 999, -1, 1'b0};
    vt[1] = '{ent(3, 96, 48), 21'd0, 1, 100, 52, 48, 48, 95, 1'b0};
    vt[2] = '{ent(3, 96, 48), 21'd0, 1, 144, 4, 0, 999, -1, 1'b0};
    vt[3] = '{ent(1, 100, 450), 21'd0, 1, 100, 52, 30, 450, 479, 1'b0};
    vt[4] = '{ent(5, 100, 500), 21'd0, 1, 100, 52, 36, 0, 35, 1'b0};
    vt[5] = '{ent(0, 0, 0), ent(2, 10, 20), 2, 20, 103, 96, 0, 67, 1'b1};
    vt[6] = '{ent(6, 100, 10), 21'd0, 1, 147, 52, 48, 10, 57, 1'b0};
    vt[7] = '{ent(6, 100, 10), 21'd0, 1, 99, 4, 0, 999, -1, 1'b0};
    vt[8] = '{ent(7, 500, 200), 21'd0, 1, 10, 52, 48, 200, 247, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", int'(address_read_ent), 0);
    chk("rst_lb_address", int'(lb_address), 0);
    chk("rst_lb_data", int'(lb_data), 0);
    chk("rst_wren", int'(lb_wren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(line_done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      mem[0] = vt[i].e0;
      mem[1] = vt[i].e1;
      model(vt[i].ly, vt[i].n);
      run(vt[i].ly, vt[i].n, vt[i].noise, cyc, wr, mn, mx, bc);
      chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d_writes", i), wr, vt[i].wr);
      chk($sformatf("v%0d_min_col", i), mn, vt[i].mn);
      chk($sformatf("v%0d_max_col", i), mx, vt[i].mx);
      chk($sformatf("v%0d_bad_cols", i), bc, 0);
    end

    mem[0] = ent(4, 100, 40);
    @(negedge clk);
    line_start = 1'b1;
    line_y = 9'd100;
    entities_number = 8'd1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_reset_wren", int'(lb_wren), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_wren", int'(lb_wren), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (lb_wren || busy || line_done) cnt++;
    end
    chk("post_reset_quiet", cnt, 0);

    for (int r = 0; r < 25; r++) begin
      ly = int'($urandom_range(0, 511));
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) begin
        y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                        : (ly - int'($urandom_range(0, 60)) + 512) % 512;
        mem[i] = ent(int'($urandom_range(0, 7)), y, int'($urandom_range(0, 511)));
      end
      model(ly, n);
      run(ly, n, 1'($urandom), cyc, wr, mn, mx, bc);
      chk($sformatf("r%0d_cycles", r), cyc, exp_cyc);
      chk($sformatf("r%0d_writes", r), wr, exp_wr);
      chk($sformatf("r%0d_bad_cols", r), bc, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
